// File: rtl/spi_master_param_if.sv
// spi_master_param_if
//   System-side handshake and SPI pin bundle for spi_master_param.
//   master modport : the SPI master block (drives busy/done/rx_byte and pins)
//   slave  modport : the system/device side (drives start request and miso)
//   Signals:
//     tx_en, mode{CPOL,CPHA}, lsb_first, cs_sel, tx_byte   start request
//     rx_byte, busy, done                                  completion side
//     sclk, mosi, miso, cs_n                               SPI pins
interface spi_master_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CS     = 2,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
);
  logic                  tx_en;
  logic [1:0]            mode;
  logic                  lsb_first;
  logic [CS_W-1:0]       cs_sel;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic [DATA_WIDTH-1:0] rx_byte;
  logic                  busy;
  logic                  done;
  logic                  sclk;
  logic                  mosi;
  logic                  miso;
  logic [NUM_CS-1:0]     cs_n;

  modport master (
    input  tx_en, mode, lsb_first, cs_sel, tx_byte, miso,
    output rx_byte, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output tx_en, mode, lsb_first, cs_sel, tx_byte, miso,
    input  rx_byte, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_param.sv
// spi_master_param
//   Parametrised SPI master: DATA_WIDTH-bit words, SCLK half-period of
//   CLK_DIV sysClk cycles, all four CPOL/CPHA modes, MSB/LSB-first order,
//   NUM_CS active-low chip selects, busy/done handshake.
//   Ports:
//     sysClk   system clock, everything on the rising edge
//     reset    synchronous, active-high
//     bus      spi_master_param_if.master (request, completion, SPI pins)
//   Transfer: IDLE -> SETUP (CLK_DIV) -> SHIFT (2*DATA_WIDTH half-periods)
//             -> HOLD (CLK_DIV) -> IDLE with a one-cycle done pulse.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 2,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                 sysClk,
  input  logic                 reset,
  spi_master_param_if.master   bus
);

  localparam int HP_W = $clog2(CLK_DIV + 1);
  localparam int EC_W = $clog2(2 * DATA_WIDTH + 1);
  localparam logic [HP_W-1:0] HP_LAST = HP_W'(CLK_DIV - 1);
  localparam logic [EC_W-1:0] EC_LAST = EC_W'(2 * DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  state_e                state_q, state_d;
  logic [HP_W-1:0]       hp_cnt_q, hp_cnt_d;
  logic [EC_W-1:0]       edge_cnt_q, edge_cnt_d;
  logic [1:0]            mode_q, mode_d;
  logic                  lsb_q, lsb_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_byte_q, rx_byte_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [NUM_CS-1:0]     cs_n_q, cs_n_d;

  logic hp_last;
  logic toggle;
  logic leading;

  // Bit that goes on the wire next, and the word with that bit consumed.
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                      input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Received bits enter from the side that makes loopback return tx_byte.
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b, input logic lsb);
    return lsb ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // Out-of-range selects match no line, so no chip select is asserted.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++)
      if (int'(sel) == i) v[i] = 1'b0;
    return v;
  endfunction

  assign hp_last = (hp_cnt_q == HP_LAST);

  always_comb begin
    state_d    = state_q;
    hp_cnt_d   = hp_cnt_q;
    edge_cnt_d = edge_cnt_q;
    mode_d     = mode_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_byte_d  = rx_byte_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    toggle     = 1'b0;
    leading    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        cs_n_d = '1;
        mosi_d = 1'b0;
        sclk_d = bus.mode[1];
        if (bus.tx_en) begin
          state_d    = SETUP;
          mode_d     = bus.mode;
          lsb_d      = bus.lsb_first;
          busy_d     = 1'b1;
          cs_n_d     = cs_decode(bus.cs_sel);
          hp_cnt_d   = '0;
          edge_cnt_d = '0;
          rx_sh_d    = '0;
          // CPHA=0 presents bit 0 during setup; CPHA=1 waits for the first leading edge.
          if (!bus.mode[0]) begin
            mosi_d  = first_bit(bus.tx_byte, bus.lsb_first);
            tx_sh_d = shift_out(bus.tx_byte, bus.lsb_first);
          end else begin
            tx_sh_d = bus.tx_byte;
          end
        end
      end
      SETUP: begin
        if (hp_last) begin
          state_d  = SHIFT;
          hp_cnt_d = '0;
          toggle   = 1'b1;
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
      end
      SHIFT: begin
        if (hp_last) begin
          hp_cnt_d = '0;
          // Last half-period already started with toggle 2*DATA_WIDTH.
          if (edge_cnt_q == EC_LAST) state_d = HOLD;
          else                       toggle  = 1'b1;
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
      end
      HOLD: begin
        if (hp_last) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_byte_d = rx_sh_q;
          cs_n_d    = '1;
          mosi_d    = 1'b0;
          sclk_d    = mode_q[1];
        end else begin
          hp_cnt_d = hp_cnt_q + HP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Toggle n (1-based) is leading when odd, i.e. when the count so far is even.
    if (toggle) begin
      sclk_d     = ~sclk_q;
      edge_cnt_d = edge_cnt_q + EC_W'(1);
      leading    = ~edge_cnt_q[0];
      if (mode_q[0] ? leading : (!leading && edge_cnt_d != EC_LAST)) begin
        mosi_d  = first_bit(tx_sh_q, lsb_q);
        tx_sh_d = shift_out(tx_sh_q, lsb_q);
      end
      if (mode_q[0] ? !leading : leading)
        rx_sh_d = shift_in(rx_sh_q, bus.miso, lsb_q);
    end
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state_q    <= IDLE;
      hp_cnt_q   <= '0;
      edge_cnt_q <= '0;
      mode_q     <= 2'b00;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_byte_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      mode_q     <= mode_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_byte_q  <= rx_byte_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign bus.rx_byte = rx_byte_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: cycle-level model of the transfer timeline plus
// a behavioural SPI slave, checked every cycle, with directed literal checks.
module tb_spi_master_param;
  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int NCS = 3;
  localparam int CSW = 2;
  localparam int L   = 1 + CD * (2 * DW + 2);

  logic sysClk = 1'b0;
  logic reset  = 1'b1;
  always #5 sysClk = ~sysClk;

  spi_master_param_if #(.DATA_WIDTH(DW), .NUM_CS(NCS), .CS_W(CSW)) bus();

  spi_master_param #(.DATA_WIDTH(DW), .CLK_DIV(CD), .NUM_CS(NCS), .CS_W(CSW)) dut (
    .sysClk (sysClk),
    .reset  (reset),
    .bus    (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic          slv_loop = 1'b0;
  logic [DW-1:0] slv_word = '0;
  logic          miso_slv;
  assign bus.miso = slv_loop ? bus.mosi : miso_slv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic           s_reset, s_tx_en, s_lsb, s_loop;
  logic [1:0]     s_mode;
  logic [CSW-1:0] s_cs;
  logic [DW-1:0]  s_tx, s_slv;
  always @(posedge sysClk) begin
    s_reset <= reset;
    s_tx_en <= bus.tx_en;
    s_mode  <= bus.mode;
    s_lsb   <= bus.lsb_first;
    s_cs    <= bus.cs_sel;
    s_tx    <= bus.tx_byte;
    s_slv   <= slv_word;
    s_loop  <= slv_loop;
  end

  // Model: transfer position k counts cycles since acceptance (k=1 first busy cycle).
  logic           m_active;
  int             m_k;
  logic [1:0]     m_mode;
  logic           m_lsb;
  logic [CSW-1:0] m_cs;
  logic [DW-1:0]  m_tx, m_slv, m_exp_rx, m_rx;
  logic           sl_prev;
  int             sl_idx, sl_cnt, sl_tog, sl_rise;
  logic [DW-1:0]  sl_in, sl_seq;
  logic [DW-1:0]  last_sl_in, last_seq;
  int             last_rise;
  logic [NCS-1:0] wd_prev_cs;

  function automatic logic sclk_at(input int k, input logic cpol);
    int h;
    if (k <= CD || k > CD * (2 * DW + 1)) return cpol;
    h = (k - 1 - CD) / CD;
    return (h % 2 == 0) ? ~cpol : cpol;
  endfunction

  function automatic logic [NCS-1:0] cs_exp(input logic [CSW-1:0] sel);
    logic [NCS-1:0] v;
    v = '1;
    if (int'(sel) < NCS) v[int'(sel)] = 1'b0;
    return v;
  endfunction

  function automatic logic word_bit(input logic [DW-1:0] w, input int j, input logic lsb);
    return lsb ? w[j] : w[DW-1-j];
  endfunction

  initial begin
    logic sclk_e, done_e, lead;
    m_active = 1'b0; m_k = 0; m_rx = '0; miso_slv = 1'b0;
    m_mode = 2'b00; m_lsb = 1'b0; m_cs = '0; m_tx = '0; m_slv = '0; m_exp_rx = '0;
    sl_prev = 1'b0; sl_idx = 0; sl_cnt = 0; sl_tog = 0; sl_rise = 0; sl_in = '0; sl_seq = '0;
    last_sl_in = '0; last_seq = '0; last_rise = 0;
    forever begin
      @(negedge sysClk);
      done_e = 1'b0;
      if (s_reset) begin
        m_active = 1'b0; m_rx = '0; sclk_e = 1'b0;
      end else if (!m_active) begin
        sclk_e = s_mode[1];
        if (s_tx_en) begin
          m_active = 1'b1; m_k = 1;
          m_mode = s_mode; m_lsb = s_lsb; m_cs = s_cs; m_tx = s_tx; m_slv = s_slv;
          m_exp_rx = s_loop ? s_tx : s_slv;
        end
      end else begin
        m_k++;
        sclk_e = sclk_at(m_k, m_mode[1]);
        if (m_k == L) begin
          m_active = 1'b0; done_e = 1'b1; m_rx = m_exp_rx;
        end
      end

      chk("busy",    {31'b0, bus.busy}, {31'b0, m_active});
      chk("done",    {31'b0, bus.done}, {31'b0, done_e});
      chk("cs_n",    32'(bus.cs_n), m_active ? 32'(cs_exp(m_cs)) : 32'(NCS'('1)));
      chk("sclk",    {31'b0, bus.sclk}, {31'b0, sclk_e});
      chk("rx_byte", 32'(bus.rx_byte), 32'(m_rx));
      if (!m_active)
        chk("mosi_idle", {31'b0, bus.mosi}, 32'd0);
      if (m_active && m_k == 1 && !m_mode[0])
        chk("mosi_first", {31'b0, bus.mosi}, {31'b0, word_bit(m_tx, 0, m_lsb)});

      if (done_e) begin
        chk("slave_rx", 32'(sl_in), 32'(m_tx));
        chk("sclk_toggles", sl_tog, 2 * DW);
        last_sl_in = sl_in; last_seq = sl_seq; last_rise = sl_rise;
      end

      // Behavioural slave, driven purely from the pins.
      if (m_active && m_k == 1) begin
        sl_idx = 0; sl_cnt = 0; sl_tog = 0; sl_rise = 0; sl_in = '0; sl_seq = '0;
        if (!m_mode[0]) miso_slv = word_bit(m_slv, 0, m_lsb);
      end else if (m_active && bus.sclk !== sl_prev) begin
        sl_tog++;
        if (bus.sclk === 1'b1) sl_rise++;
        lead = (bus.sclk !== m_mode[1]);
        if (lead ^ m_mode[0]) begin
          if (sl_cnt < DW) begin
            if (m_lsb) sl_in[sl_cnt] = bus.mosi;
            else       sl_in[DW-1-sl_cnt] = bus.mosi;
            sl_seq = {sl_seq[DW-2:0], bus.mosi};
            sl_cnt++;
          end
        end else if (!m_mode[0]) begin
          sl_idx++;
          if (sl_idx < DW) miso_slv = word_bit(m_slv, sl_idx, m_lsb);
        end else begin
          if (sl_idx < DW) miso_slv = word_bit(m_slv, sl_idx, m_lsb);
          sl_idx++;
        end
      end
      sl_prev = bus.sclk;
    end
  end

  task automatic start(input logic [1:0] m, input logic lsb, input logic [CSW-1:0] cs,
                       input logic [DW-1:0] tx, input logic [DW-1:0] slv, input logic loop);
    @(posedge sysClk); #1;
    bus.mode = m; bus.lsb_first = lsb; bus.cs_sel = cs; bus.tx_byte = tx;
    slv_word = slv; slv_loop = loop; bus.tx_en = 1'b1;
    @(posedge sysClk); #1;
    bus.tx_en = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    wd_prev_cs = bus.cs_n;
    while (n < 400) begin
      @(negedge sysClk);
      n++;
      if (bus.done === 1'b1) break;
      wd_prev_cs = bus.cs_n;
    end
    #1;
    chk("done_seen", {31'b0, bus.done}, 32'd1);
  endtask

  initial begin
    int n;
    logic [1:0]     rm;
    logic           rl, rlp;
    logic [CSW-1:0] rc;
    logic [DW-1:0]  rt, rs;
    bus.tx_en = 1'b0; bus.mode = 2'b00; bus.lsb_first = 1'b0; bus.cs_sel = '0; bus.tx_byte = '0;
    repeat (3) @(posedge sysClk);
    #1 reset = 1'b0;
    repeat (2) @(posedge sysClk);

    // Loopback, mode 0, MSB-first.
    start(2'd0, 1'b0, 2'd0, 8'hA5, 8'h00, 1'b1);
    wait_done(n);
    chk("latency", n, 37);
    chk("loop_rx", 32'(bus.rx_byte), 32'h0000_00A5);
    chk("mosi_seq", 32'(last_seq), 32'b1010_0101);
    chk("sclk_rises", last_rise, 8);

    // Modes 1..3 against a slave returning 0x3C.
    for (int m = 1; m < 4; m++) begin
      start(2'(m), 1'b0, 2'd0, 8'hC3, 8'h3C, 1'b0);
      wait_done(n);
      chk("mode_rx", 32'(bus.rx_byte), 32'h3C);
      chk("mode_slave_rx", 32'(last_sl_in), 32'hC3);
      @(negedge sysClk);
      chk("sclk_idle", {31'b0, bus.sclk}, 32'(m >> 1));
    end

    // LSB-first.
    start(2'd0, 1'b1, 2'd0, 8'h01, 8'h00, 1'b1);
    @(negedge sysClk);
    chk("lsb_first_bit", {31'b0, bus.mosi}, 32'd1);
    wait_done(n);
    chk("lsb_loop_rx", 32'(bus.rx_byte), 32'h01);
    start(2'd0, 1'b1, 2'd0, 8'h5A, 8'h80, 1'b0);
    wait_done(n);
    chk("lsb_slave_rx", 32'(bus.rx_byte), 32'h80);

    // Chip-select routing, in range and out of range.
    start(2'd0, 1'b0, 2'd1, 8'h96, 8'h00, 1'b1);
    @(negedge sysClk);
    chk("cs1_first", 32'(bus.cs_n), 32'b101);
    wait_done(n);
    chk("cs1_last", 32'(wd_prev_cs), 32'b101);
    chk("cs1_done", 32'(bus.cs_n), 32'b111);
    start(2'd0, 1'b0, 2'd3, 8'h69, 8'h00, 1'b1);
    @(negedge sysClk);
    chk("cs3_none", 32'(bus.cs_n), 32'b111);
    wait_done(n);
    chk("cs3_latency", n, 36);
    chk("cs3_rx", 32'(bus.rx_byte), 32'h69);

    // tx_en held high: back-to-back with a single cs_n gap cycle.
    @(posedge sysClk); #1;
    bus.mode = 2'd0; bus.lsb_first = 1'b0; bus.cs_sel = 2'd0; bus.tx_byte = 8'h3E;
    slv_loop = 1'b1; bus.tx_en = 1'b1;
    wait_done(n);
    chk("b2b_gap", 32'(bus.cs_n), 32'b111);
    @(negedge sysClk);
    chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    chk("b2b_cs", 32'(bus.cs_n), 32'b110);
    wait_done(n);
    bus.tx_en = 1'b0;
    chk("b2b_latency", n, L - 1);

    // Reset in the middle of a transfer.
    start(2'd0, 1'b0, 2'd0, 8'hF0, 8'h00, 1'b1);
    repeat (9) @(posedge sysClk);
    #1 reset = 1'b1;
    @(posedge sysClk); #1 reset = 1'b0;
    @(negedge sysClk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_cs", 32'(bus.cs_n), 32'b111);
    chk("rst_sclk", {31'b0, bus.sclk}, 32'd0);
    chk("rst_rx", 32'(bus.rx_byte), 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    start(2'd3, 1'b0, 2'd2, 8'h81, 8'h00, 1'b1);
    wait_done(n);
    chk("post_rst_rx", 32'(bus.rx_byte), 32'h81);

    // Random transfers with input noise while busy.
    for (int t = 0; t < 12; t++) begin
      rm = 2'($urandom_range(0, 3)); rl = 1'($urandom_range(0, 1));
      rc = CSW'($urandom_range(0, 3)); rt = DW'($urandom); rs = DW'($urandom);
      rlp = 1'($urandom_range(0, 1));
      start(rm, rl, rc, rt, rs, rlp);
      for (int c = 0; c < 20; c++) begin
        @(posedge sysClk); #1;
        bus.tx_en = 1'($urandom_range(0, 1)); bus.mode = 2'($urandom_range(0, 3));
        bus.lsb_first = 1'($urandom_range(0, 1)); bus.cs_sel = CSW'($urandom_range(0, 3));
        bus.tx_byte = DW'($urandom);
      end
      @(posedge sysClk); #1 bus.tx_en = 1'b0;
      wait_done(n);
      chk("rand_rx", 32'(bus.rx_byte), 32'(rlp ? rt : rs));
    end

    repeat (3) @(posedge sysClk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
